// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: line-refill sequencer and sole driver of one cache bank's write port.
// Define CACHE_REFILL_CRITICAL_WORD_FIRST_EN to start each burst at the missing word.
module cache_refill_ctrl #(
    parameter int DATA_WIDTH         = 32,
    parameter int INDEX_WIDTH        = 6,
    parameter int BLOCK_OFFSET_WIDTH = 2,
    localparam int ADDR_WIDTH        = INDEX_WIDTH + BLOCK_OFFSET_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_miss_valid,
    input  logic [INDEX_WIDTH-1:0]        i_miss_index,
    input  logic [BLOCK_OFFSET_WIDTH-1:0] i_miss_offset,
    output logic                          o_miss_ready,
    output logic                          o_mem_req_valid,
    output logic [INDEX_WIDTH-1:0]        o_mem_req_index,
    output logic [BLOCK_OFFSET_WIDTH-1:0] o_mem_req_offset,
    input  logic                          i_mem_req_ready,
    input  logic                          i_mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]         i_mem_resp_data,
    input  logic                          i_cpu_we,
    input  logic [ADDR_WIDTH-1:0]         i_cpu_waddr,
    input  logic [DATA_WIDTH-1:0]         i_cpu_wdata,
    output logic                          o_cpu_wready,
    output logic                          o_bank_we,
    output logic [ADDR_WIDTH-1:0]         o_bank_waddr,
    output logic [DATA_WIDTH-1:0]         o_bank_wdata,
    output logic                          o_refill_done,
    output logic [INDEX_WIDTH-1:0]        o_refill_index,
    output logic                          o_busy
);
    typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

    state_t                        state;
    logic [INDEX_WIDTH-1:0]        idx;
    logic [BLOCK_OFFSET_WIDTH-1:0] start_off, cnt, miss_start, fill_off;
    logic                          fill, pass;

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    assign miss_start = i_miss_offset;
`else
    logic unused_offset;
    assign miss_start    = '0;
    assign unused_offset = ^i_miss_offset;
`endif

    assign fill     = state == FILL;
    assign pass     = state == IDLE || state == DONE;
    assign fill_off = start_off + cnt;

    assign o_mem_req_index  = idx;
    assign o_mem_req_offset = start_off;

    // The refill owns the port in FILL; CPU stores only pass in IDLE and DONE.
    assign o_cpu_wready = rst_n && pass;
    assign o_bank_we    = rst_n && (fill ? i_mem_resp_valid : pass && i_cpu_we);
    assign o_bank_waddr = fill ? {idx, fill_off} : i_cpu_waddr;
    assign o_bank_wdata = fill ? i_mem_resp_data : i_cpu_wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            idx             <= '0;
            start_off       <= '0;
            cnt             <= '0;
            o_miss_ready    <= 1'b1;
            o_mem_req_valid <= 1'b0;
            o_busy          <= 1'b0;
            o_refill_done   <= 1'b0;
            o_refill_index  <= '0;
        end else begin
            case (state)
                IDLE: if (i_miss_valid) begin
                    state           <= REQ;
                    idx             <= i_miss_index;
                    start_off       <= miss_start;
                    cnt             <= '0;
                    o_miss_ready    <= 1'b0;
                    o_mem_req_valid <= 1'b1;
                    o_busy          <= 1'b1;
                end
                REQ: if (i_mem_req_ready) begin
                    state           <= FILL;
                    o_mem_req_valid <= 1'b0;
                end
                FILL: if (i_mem_resp_valid) begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        state          <= DONE;
                        o_busy         <= 1'b0;
                        o_refill_done  <= 1'b1;
                        o_refill_index <= idx;
                    end
                end
                default: begin
                    state         <= IDLE;
                    o_refill_done <= 1'b0;
                    o_miss_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Sequencer and write-port arbiter for one data `cache_bank`. It accepts a line miss, issues a single burst read to memory, and streams the returned words into the bank's write port. While no refill is in progress, it passes CPU store writes through to the same port. It sits between the cache hit/miss logic, the memory interface and the bank, and is the only block that drives the bank's `i_we`, `i_waddr` and `i_wdata`.

## Interface
- `DATA_WIDTH`, 32, width of one word and of the bank data.
- `INDEX_WIDTH`, 6, line index width.
- `BLOCK_OFFSET_WIDTH`, 2, word-in-line width; words per line W = 1 << `BLOCK_OFFSET_WIDTH`; bank `ADDR_WIDTH` = `INDEX_WIDTH` + `BLOCK_OFFSET_WIDTH`.

Ports (name, direction, width, meaning):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `i_miss_valid`  in  1  refill request.
- `i_miss_index`  in  `INDEX_WIDTH`  line to refill.
- `i_miss_offset`  in  `BLOCK_OFFSET_WIDTH`  word that missed.
- `o_miss_ready`  out  1  request accepted this cycle when high together with `i_miss_valid`.
- `o_mem_req_valid`  out  1  burst read request.
- `o_mem_req_index`  out  `INDEX_WIDTH`  line of the request.
- `o_mem_req_offset`  out  `BLOCK_OFFSET_WIDTH`  first word of the burst.
- `i_mem_req_ready`  in  1  memory accepts the request.
- `i_mem_resp_valid`  in  1  one returned word.
- `i_mem_resp_data`  in  `DATA_WIDTH`  returned word.
- `i_cpu_we`  in  1  CPU store write.
- `i_cpu_waddr`  in  `INDEX_WIDTH`+`BLOCK_OFFSET_WIDTH`  store address.
- `i_cpu_wdata`  in  `DATA_WIDTH`  store data.
- `o_cpu_wready`  out  1  store is written this cycle.
- `o_bank_we`, `o_bank_waddr`, `o_bank_wdata`  out  bank write port.
- `o_refill_done`  out  1  one-cycle pulse: the line is complete.
- `o_refill_index`  out  `INDEX_WIDTH`  line just completed, valid with `o_refill_done`.
- `o_busy`  out  1  high in REQ and FILL.

## Operation
- **States.** The FSM has four states: IDLE, REQ, FILL, DONE.
- **IDLE.**
  - `o_miss_ready`=1.
  - On `i_miss_valid`, latch index and start offset, clear the word counter, and go to REQ.
- **REQ.**
  - `o_mem_req_valid`=1, with index and offset held stable.
  - On `i_mem_req_ready`, go to FILL.
- **FILL.**
  - Each `i_mem_resp_valid` writes bank address {index, (start + cnt) mod W} with `i_mem_resp_data`, then increments cnt.
  - Offset arithmetic is `BLOCK_OFFSET_WIDTH`-bit and wraps naturally.
  - The response with cnt = W-1 moves the FSM to DONE.
- **DONE.**
  - `o_refill_done`=1 and `o_refill_index` = latched index for exactly one cycle.
  - Then go to IDLE.
- **Write-port sharing.**
  - In IDLE and DONE, CPU writes pass through combinationally: `o_bank_*` = `i_cpu_*`, `o_cpu_wready`=1.
  - In REQ and FILL, `o_cpu_wready`=0 and CPU writes are not performed. The CPU holds its store until `o_cpu_wready` is high.
  - The refill always wins the port.
- **Simultaneous events.**
  - A miss and a CPU write in the same IDLE cycle both proceed: the store is written and the miss is latched.
  - A miss arriving in DONE waits until IDLE.
- **Ignored inputs.** `i_mem_resp_valid` outside FILL and `i_mem_req_ready` outside REQ are ignored.
- **Reset mid-operation.**
  - Return to IDLE and clear the counter.
  - No done pulse; the partially filled line is left as is. The requester must re-issue the miss.

## Timing
- **Reset values:**
  - state IDLE
  - `o_miss_ready`=1
  - `o_mem_req_valid`=0
  - `o_busy`=0
  - `o_refill_done`=0
  - `o_refill_index`=0
  - `o_bank_we`=0 (forced while `rst_n`=0)
  - `o_cpu_wready`=0 while `rst_n`=0
- **Latencies** (miss accepted at cycle T):
  - `o_mem_req_valid` rises at T+1.
  - With `i_mem_req_ready` at T+1 and one response per cycle, bank writes occur at T+2..T+W+1.
  - `o_refill_done` pulses at T+W+2.
  - The next miss can be accepted at T+W+3.
- **Bank write port.** Bank writes are combinational from the response, in the same cycle. `cache_bank` forwards a same-address read on the following cycle, so readers see the new word without extra delay.
- **Response gaps.** Gaps between responses are allowed; the counter advances only on `i_mem_resp_valid`.

## Configuration
- `CACHE_REFILL_CRITICAL_WORD_FIRST_EN` defined:
  - Start offset = `i_miss_offset`.
  - `o_mem_req_offset` = `i_miss_offset`.
  - Words are written in wrapping order from it.
- Not defined:
  - Start offset is always 0.
  - `o_mem_req_offset`=0.
  - `i_miss_offset` is unused.

## Test plan
(W=4, `INDEX_WIDTH`=6.)
- **Basic refill.** Miss index 5, `i_mem_req_ready` immediately, data A0..A3 back-to-back → bank writes at addresses 20, 21, 22, 23 (non-CWF), `o_refill_done` with index 5 at T+6.
- **Critical word first.** Macro defined, miss index 2, offset 3 → `o_mem_req_offset`=3, writes to addresses 11, 8, 9, 10 in that order.
- **Port contention.**
  - CPU store to address 40 during FILL → `o_cpu_wready`=0 and the store is not written.
  - The same store held until DONE → written at DONE with `o_cpu_wready`=1.
- **Memory stalls.** `i_mem_req_ready` delayed 3 cycles and one idle cycle between each response → `o_mem_req_valid` held with a stable index, exactly 4 writes, a single done pulse.
- **Reset mid-refill.** `rst_n` low after 2 words → next cycle IDLE, `o_busy`=0, no `o_refill_done`; a new miss afterwards completes normally.
- **Simultaneous miss and store in IDLE.** CPU store to address 7 with value 0xDEADBEEF plus a miss on index 9 → the store is written that cycle and the refill of line 9 follows.
